btn_debounce: RTL and testbench

Input-side conditioner for the board's push buttons and slide switches: synchronizes N raw asynchronous inputs, debounces each with a stability counter, and emits a clean level plus single-cycle press, release and auto-repeat pulses. It sits between the pins and the counter/control logic, for example driving the up/down counter's enable and select from buttons instead of raw switches. Each channel is an independent four-state machine. All channels run on the undivided system clock.

---
 rtl/btn_pkg.sv | 16 +
 rtl/btn_channel.sv | 133 +++++++++++++
 rtl/btn_debounce.sv | 36 +++
 tb/tb_btn_debounce.sv | 118 +++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared state encoding and counter-width helper for the button conditioner.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONF_HI = 2'd1,
        HELD    = 2'd2,
        CONF_LO = 2'd3
    } btn_state_e;

    // Bits needed to hold a counter whose terminal value is max_term.
    function automatic int unsigned cnt_width(input int unsigned max_term);
        return (max_term < 1) ? 1 : $clog2(max_term + 1);
    endfunction

endpackage

// File: rtl/btn_channel.sv
// One button: 2-flop synchronizer, debounce FSM, repeat timer; outputs registered,
// press lands DEBOUNCE_CYCLES+2 edges after a stable input change; no backpressure.
module btn_channel
    import btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned REPEAT_DELAY    = 50_000_000,
    parameter int unsigned REPEAT_PERIOD   = 10_000_000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic inp_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic rpt_o
);

    localparam int unsigned DB_W   = cnt_width(DEBOUNCE_CYCLES - 1);
    localparam int unsigned RT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY - 1
                                                                    : REPEAT_PERIOD - 1;
    localparam int unsigned RT_W   = cnt_width(RT_MAX);

    localparam logic [DB_W-1:0] DB_TERM     = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RT_W-1:0] DELAY_TERM  = RT_W'(REPEAT_DELAY - 1);
    localparam logic [RT_W-1:0] PERIOD_TERM = RT_W'(REPEAT_PERIOD - 1);

    logic [1:0]      sync_q;
    btn_state_e      state_q, state_d;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic [RT_W-1:0] rt_cnt_q, rt_cnt_d;
    logic            rt_per_q, rt_per_d;
    logic            level_q, level_d;
    logic            press_q, press_d;
    logic            release_q, release_d;
    logic            rpt_q, rpt_d;
    logic            s;
    logic [RT_W-1:0] rt_term;

    assign s       = sync_q[1];
    // After the first repeat the timer runs on the shorter period.
    assign rt_term = rt_per_q ? PERIOD_TERM : DELAY_TERM;

    always_comb begin
        state_d   = state_q;
        db_cnt_d  = db_cnt_q;
        rt_cnt_d  = rt_cnt_q;
        rt_per_d  = rt_per_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        rpt_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (s) begin
                    state_d  = CONF_HI;
                    db_cnt_d = '0;
                end
            end
            CONF_HI: begin
                if (!s) begin
                    state_d = IDLE;
                end else if (db_cnt_q == DB_TERM) begin
                    state_d  = HELD;
                    press_d  = 1'b1;
                    rpt_d    = 1'b1;
                    rt_cnt_d = '0;
                    rt_per_d = 1'b0;
                end else begin
                    db_cnt_d = db_cnt_q + 1'b1;
                end
            end
            HELD: begin
                if (!s) begin
                    state_d  = CONF_LO;
                    db_cnt_d = '0;
                end
                if (rt_cnt_q == rt_term) begin
                    rpt_d    = 1'b1;
                    rt_cnt_d = '0;
                    rt_per_d = 1'b1;
                end else begin
                    rt_cnt_d = rt_cnt_q + 1'b1;
                end
            end
            CONF_LO: begin
                // A repeat falling due here parks at the terminal count until HELD.
                if (rt_cnt_q != rt_term) begin
                    rt_cnt_d = rt_cnt_q + 1'b1;
                end
                if (s) begin
                    state_d = HELD;
                end else if (db_cnt_q == DB_TERM) begin
                    state_d   = IDLE;
                    release_d = 1'b1;
                end else begin
                    db_cnt_d = db_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        level_d = (state_d == HELD) || (state_d == CONF_LO);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q    <= '0;
            state_q   <= IDLE;
            db_cnt_q  <= '0;
            rt_cnt_q  <= '0;
            rt_per_q  <= 1'b0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            rpt_q     <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], inp_i};
            state_q   <= state_d;
            db_cnt_q  <= db_cnt_d;
            rt_cnt_q  <= rt_cnt_d;
            rt_per_q  <= rt_per_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            rpt_q     <= rpt_d;
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;
    assign rpt_o     = rpt_q;

endmodule

// File: rtl/btn_debounce.sv
// N independent debounced button channels with press/release/auto-repeat pulses;
// registered outputs, DEBOUNCE_CYCLES+2 edge latency per accepted edge; no backpressure.
module btn_debounce
    import btn_pkg::*;
#(
    parameter int unsigned N_BTN           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned REPEAT_DELAY    = 50_000_000,
    parameter int unsigned REPEAT_PERIOD   = 10_000_000
) (
    input  logic             btn_debounce_clk,
    input  logic             btn_debounce_rst,
    input  logic [N_BTN-1:0] btn_debounce_inp,
    output logic [N_BTN-1:0] btn_debounce_level,
    output logic [N_BTN-1:0] btn_debounce_press,
    output logic [N_BTN-1:0] btn_debounce_release,
    output logic [N_BTN-1:0] btn_debounce_rpt
);

    for (genvar g = 0; g < N_BTN; g++) begin : g_ch
        btn_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_ch (
            .clk_i     (btn_debounce_clk),
            .rst_i     (btn_debounce_rst),
            .inp_i     (btn_debounce_inp[g]),
            .level_o   (btn_debounce_level[g]),
            .press_o   (btn_debounce_press[g]),
            .release_o (btn_debounce_release[g]),
            .rpt_o     (btn_debounce_rpt[g])
        );
    end

endmodule

// File: tb/tb_btn_debounce.sv
// Directed cycle-by-cycle check of two debounce channels against hand-derived pulse timing.
module tb_btn_debounce;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] inp;
    logic [1:0] level, press, rel, rpt;
    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;

    always #5 clk = ~clk;

    btn_debounce #(
        .N_BTN           (2),
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (10),
        .REPEAT_PERIOD   (5)
    ) dut (
        .btn_debounce_clk     (clk),
        .btn_debounce_rst     (rst),
        .btn_debounce_inp     (inp),
        .btn_debounce_level   (level),
        .btn_debounce_press   (press),
        .btn_debounce_release (rel),
        .btn_debounce_rpt     (rpt)
    );

    task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed {lvl,prs,rel,rpt}=%b expected %b", tag, obs, exp);
        end
    endtask

    // Inputs set here are sampled at edge cyc+1; outputs are read 1ns after that edge.
    task automatic tick(input logic [1:0] v, input logic r);
        @(negedge clk);
        inp = v;
        rst = r;
        @(posedge clk);
        cyc++;
        #1;
    endtask

    // One hold episode: press at p, level until lvl_end, optional release at lvl_end,
    // repeats at p, p+10, then every 5 cycles while c < rpt_lim. Returns {lvl,prs,rel,rpt}.
    function automatic logic [3:0] ch_exp(input int p, input int lvl_end, input bit has_rel,
                                          input int rpt_lim, input int c);
        logic [3:0] e;
        e[3] = (c >= p) && (c < lvl_end);
        e[2] = (c == p);
        e[1] = has_rel && (c == lvl_end);
        e[0] = (c >= p) && (c < rpt_lim) &&
               ((c == p) || ((c >= p + 10) && (((c - p - 10) % 5) == 0)));
        return e;
    endfunction

    function automatic logic [7:0] exp_out(input int s, input int c);
        logic [3:0] a, b;
        a = 4'b0;
        b = 4'b0;
        case (s)
            0: a = ch_exp(16, 1000, 0, 1000, c);
            1: a = ch_exp(26, 1000, 0, 1000, c);
            2: a = ch_exp(16, 46, 1, 46, c);
            3: a = ch_exp(16, 20, 0, 20, c) | ch_exp(27, 1000, 0, 1000, c);
            4: begin
                a = ch_exp(16, 1000, 0, 1000, c);
                b = ch_exp(16, 34, 1, 31, c);
            end
            default: a = 4'b0;
        endcase
        return {b[3], a[3], b[2], a[2], b[1], a[1], b[0], a[0]};
    endfunction

    function automatic logic [1:0] stim_inp(input int s, input int c);
        logic [1:0] v;
        v = 2'b00;
        case (s)
            0: v[0] = (c >= 10);
            1: v[0] = (c >= 20) || (c == 12) || (c == 13) || (c == 16) || (c == 17);
            2: v[0] = (c >= 10) && (c < 40) && (c != 25) && (c != 26);
            3: v[0] = (c >= 10);
            4: begin
                v[0] = (c >= 10);
                v[1] = (c >= 10) && (c < 28);
            end
            default: v = 2'b00;
        endcase
        return v;
    endfunction

    task automatic run_scn(input int s, input int ncyc);
        tick(2'b00, 1'b1);
        tick(2'b00, 1'b1);
        check_val($sformatf("s%0d_reset", s), {level, press, rel, rpt}, 8'h00);
        cyc = 0;
        for (int i = 0; i < ncyc; i++) begin
            tick(stim_inp(s, cyc + 1), (s == 3) && (cyc + 1 == 20));
            check_val($sformatf("s%0d_c%0d", s, cyc), {level, press, rel, rpt}, exp_out(s, cyc));
        end
    endtask

    initial begin
        rst = 1'b1;
        inp = 2'b00;
        run_scn(0, 45);   // clean press and auto-repeat
        run_scn(1, 40);   // bouncing press
        run_scn(2, 55);   // short dropout then sustained release
        run_scn(3, 40);   // reset during a hold
        run_scn(4, 45);   // two channels, one released
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
